mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
- Arbitrates a single unified memory port between the instruction-fetch side (read-only) and the data-memory side (read/write) of the 5-stage pipeline.
- Issues one memory transaction at a time, waits for the memory's ready/acknowledge, then returns the result to the winning requester.
- Generates the stall signals that freeze the pipeline while a requester waits.
- Includes a watchdog that recovers from a memory that never responds.

Parameters:
- ADDR_W, 16, address width of all ports.
- DATA_W, 16, data width of all ports.
- TIMEOUT, 64, maximum cycles spent waiting for mem_rdy before the watchdog aborts (must be ≥2).

Ports:
- clk  in  1  global clock.
- rst_n  in  1  reset; asynchronous, active-low.
- i_req  in  1  fetch request; level, held until i_ready.
- i_addr  in  ADDR_W  fetch address.
- i_cancel  in  1  branch flush; the outstanding or pending fetch is discarded.
- i_rdata  out  DATA_W  fetched instruction; registered.
- i_ready  out  1  one-cycle pulse; i_rdata is valid this cycle.
- i_stall  out  1  fetch side must hold.
- d_re  in  1  data read request; level, held until d_ready.
- d_we  in  1  data write request; level, held until d_ready.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  write data.
- d_rdata  out  DATA_W  read data; registered.
- d_ready  out  1  one-cycle pulse marking read data valid or write complete.
- d_stall  out  1  MEM stage must hold.
- mem_addr  out  ADDR_W  memory address; registered, held for the whole transaction.
- mem_wdata  out  DATA_W  memory write data; registered.
- mem_re  out  1  memory read strobe; one-cycle pulse.
- mem_we  out  1  memory write strobe; one-cycle pulse.
- mem_rdata  in  DATA_W  memory read data, valid when mem_rdy=1.
- mem_rdy  in  1  memory completion pulse; asserted no earlier than the cycle after the strobe.
- err  out  1  sticky watchdog error flag.

Behaviour:
- Reset values: all outputs 0, state IDLE, watchdog counter 0.
- States:
  - IDLE: no transaction outstanding.
  - I_WAIT: fetch outstanding.
  - D_WAIT: data access outstanding.
- Grant rule (IDLE only): the data side has fixed priority over fetch, because the data requester is the older instruction.
- Grant is blocked in any cycle where i_ready or d_ready is 1. This prevents a stale level request from being re-issued.
- Data grant, at edge:
  - mem_addr <= d_addr.
  - If d_we: mem_we <= 1 and mem_wdata <= d_wdata. Otherwise mem_re <= 1.
  - State -> D_WAIT.
  - d_re and d_we together are treated as a write.
- Fetch grant, at edge (when i_req & ~i_cancel & no data request): mem_addr <= i_addr, mem_re <= 1, state -> I_WAIT.
- Strobes are high for exactly the one cycle after the grant edge.
- In I_WAIT or D_WAIT, on mem_rdy=1:
  - Latch mem_rdata into i_rdata or d_rdata. d_rdata is left unchanged for writes.
  - Pulse i_ready or d_ready for one cycle.
  - State -> IDLE.
- Minimum latency: request first seen at edge 0 → strobe in cycle 1 → mem_rdy in cycle 2 (earliest) → ready pulse in cycle 3.
- Cancel:
  - i_cancel=1 at any edge while in I_WAIT sets a discard flag.
  - When mem_rdy arrives, state -> IDLE, i_ready stays 0 and i_rdata is not updated.
  - The flag clears on return to IDLE.
  - i_cancel in IDLE suppresses the fetch grant in that cycle only.
- Stalls (combinational):
  - i_stall = i_req & ~i_ready.
  - d_stall = (d_re|d_we) & ~d_ready.
- Watchdog:
  - Counter clears on every grant and increments each cycle in a WAIT state.
  - If the count reaches TIMEOUT-1 without mem_rdy: err <= 1 (sticky until reset).
  - On that abort the winning requester gets a ready pulse with rdata = all ones (16'hFFFF), and state -> IDLE.
  - A late mem_rdy arriving in IDLE is ignored.
- mem_rdy arriving in IDLE is ignored in all cases and has no effect on state.
- Reset asserted mid-transaction: immediate return to IDLE, strobes and ready pulses deasserted; err cleared.

Test Plan:
- Fetch only: i_req=1, i_addr=0x0010, memory returns 0xB123 with mem_rdy one cycle after mem_re → mem_re high in cycle 1 with mem_addr=0x0010; i_ready and i_rdata=0xB123 in cycle 3; i_stall=1 in cycles 0–2.
- Contention: i_req and d_re asserted together (i_addr=0x0004, d_addr=0x8000) → data is served first (mem_addr=0x8000); fetch is issued only after the d_ready cycle, with mem_addr=0x0004; no back-to-back grant in the ready cycle.
- Write: d_we=1, d_addr=0x0100, d_wdata=0x55AA → mem_we pulses one cycle with mem_wdata=0x55AA; d_ready pulses on the ack; d_rdata unchanged; mem_re stays 0.
- Cancel: i_cancel pulsed while in I_WAIT → i_ready never asserts; i_rdata keeps its old value; state returns to IDLE when mem_rdy arrives.
- Watchdog: TIMEOUT=8 and memory never asserts mem_rdy after a d_re → err=1 and d_ready pulse with d_rdata=0xFFFF, 8 cycles after the grant; a later spurious mem_rdy causes no change.
- Reset: rst_n asserted low mid-D_WAIT → all outputs 0 asynchronously; after release, a new request is served normally with err=0.

Source files
------------

// File: rtl/mem_arbiter.sv
// Arbitrates one unified memory port between instruction fetch and data access.
// The data side has fixed priority. A watchdog aborts any transaction the memory never acknowledges.
module mem_arbiter #(
   parameter int ADDR_W  = 16,
   parameter int DATA_W  = 16,
   parameter int TIMEOUT = 64
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_req,
   input  logic [ADDR_W-1:0] i_addr,
   input  logic              i_cancel,
   output logic [DATA_W-1:0] i_rdata,
   output logic              i_ready,
   output logic              i_stall,
   input  logic              d_re,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic [DATA_W-1:0] d_rdata,
   output logic              d_ready,
   output logic              d_stall,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_re,
   output logic              mem_we,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_rdy,
   output logic              err
);

   typedef enum logic [1:0] {IDLE, I_WAIT, D_WAIT} state_t;

   localparam int               CNT_W   = $clog2(TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
   logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
   logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
   logic              mem_re_q, mem_re_d, mem_we_q, mem_we_d;
   logic              i_ready_q, i_ready_d, d_ready_q, d_ready_d;
   logic              err_q, err_d;
   logic              discard_q, discard_d;
   logic              write_q, write_d;
   logic [CNT_W-1:0]  wd_cnt_q, wd_cnt_d;

   logic              d_req;
   logic              grant_ok;
   logic              expired;
   logic              finish;
   logic [DATA_W-1:0] resp_data;

   assign d_req     = d_re | d_we;
   // A requester still holds its level request in its ready cycle; never re-grant it then.
   assign grant_ok  = ~(i_ready_q | d_ready_q);
   assign expired   = ~mem_rdy & (wd_cnt_q == CNT_MAX);
   assign finish    = mem_rdy | expired;
   assign resp_data = mem_rdy ? mem_rdata : '1;

   assign i_stall   = i_req & ~i_ready_q;
   assign d_stall   = d_req & ~d_ready_q;

   // NOTE: every _d gets a default before the case so no path leaves a signal unassigned (no latches).
   always_comb begin
      state_d     = state_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      i_rdata_d   = i_rdata_q;
      d_rdata_d   = d_rdata_q;
      err_d       = err_q;
      discard_d   = discard_q;
      write_d     = write_q;
      wd_cnt_d    = wd_cnt_q;
      mem_re_d    = 1'b0;
      mem_we_d    = 1'b0;
      i_ready_d   = 1'b0;
      d_ready_d   = 1'b0;

      unique case (state_q)
         IDLE: begin
            discard_d = 1'b0;
            if (grant_ok && d_req) begin
               mem_addr_d = d_addr;
               write_d    = d_we;
               wd_cnt_d   = '0;
               state_d    = D_WAIT;
               if (d_we) begin
                  mem_we_d    = 1'b1;
                  mem_wdata_d = d_wdata;
               end else begin
                  mem_re_d = 1'b1;
               end
            end else if (grant_ok && i_req && !i_cancel) begin
               mem_addr_d = i_addr;
               mem_re_d   = 1'b1;
               wd_cnt_d   = '0;
               state_d    = I_WAIT;
            end
         end

         I_WAIT: begin
            wd_cnt_d = wd_cnt_q + 1'b1;
            if (i_cancel) discard_d = 1'b1;
            if (finish) begin
               state_d   = IDLE;
               discard_d = 1'b0;
               err_d     = err_q | expired;
               // A flush on the completing edge also drops the response.
               if (!(discard_q || i_cancel)) begin
                  i_rdata_d = resp_data;
                  i_ready_d = 1'b1;
               end
            end
         end

         D_WAIT: begin
            wd_cnt_d = wd_cnt_q + 1'b1;
            if (finish) begin
               state_d   = IDLE;
               err_d     = err_q | expired;
               d_ready_d = 1'b1;
               // Writes keep d_rdata on a normal ack; an abort always reports all ones.
               if (!write_q || expired) d_rdata_d = resp_data;
            end
         end

         default: state_d = IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         i_rdata_q   <= '0;
         d_rdata_q   <= '0;
         mem_re_q    <= 1'b0;
         mem_we_q    <= 1'b0;
         i_ready_q   <= 1'b0;
         d_ready_q   <= 1'b0;
         err_q       <= 1'b0;
         discard_q   <= 1'b0;
         write_q     <= 1'b0;
         wd_cnt_q    <= '0;
      end else begin
         state_q     <= state_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         i_rdata_q   <= i_rdata_d;
         d_rdata_q   <= d_rdata_d;
         mem_re_q    <= mem_re_d;
         mem_we_q    <= mem_we_d;
         i_ready_q   <= i_ready_d;
         d_ready_q   <= d_ready_d;
         err_q       <= err_d;
         discard_q   <= discard_d;
         write_q     <= write_d;
         wd_cnt_q    <= wd_cnt_d;
      end
   end

   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign mem_re    = mem_re_q;
   assign mem_we    = mem_we_q;
   assign i_rdata   = i_rdata_q;
   assign i_ready   = i_ready_q;
   assign d_rdata   = d_rdata_q;
   assign d_ready   = d_ready_q;
   assign err       = err_q;

endmodule
